// File: rtl/tt_eval_pkg.sv
// Shared types and constants for the truth-table evaluator.
package tt_eval_pkg;

  // Serial table loader states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Largest supported number of logic inputs (64-entry table).
  localparam int MAX_N_IN = 6;

  // Width of the settle counter.
  localparam int CNT_W = 8;

endpackage : tt_eval_pkg

// File: rtl/tt_settle_timer.sv
// Settle timer: reloads to DELAY-1 on load, counts down to zero and
// holds there; done flags that the input vector has been stable long enough.
module tt_settle_timer
  import tt_eval_pkg::*;
#(
  parameter int DELAY = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DELAY - 1);

  logic [CNT_W-1:0] r_cnt;

  assign done = (r_cnt == '0);

  // Reload on request, otherwise count down and saturate at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= RELOAD;
    end else if (load) begin
      r_cnt <= RELOAD;
    end else if (!done) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule : tt_settle_timer

// File: rtl/truth_table_eval.sv
// Truth-table evaluator: a registered lookup of an N_IN-input function whose
// table is reloadable serially (MSB first) and swapped in atomically.
module truth_table_eval
  import tt_eval_pkg::*;
#(
  parameter int                     N_IN        = 3,
  parameter int                     DELAY       = 4,
  parameter logic [(1<<N_IN)-1:0]   RESET_TABLE = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] in,
  input  logic            cfg_valid,
  input  logic            cfg_data,
  input  logic            cfg_abort,
  output logic            cfg_ready,
  output logic            out,
  output logic            out_valid
);

  localparam int TBL_W = 1 << N_IN;
  // Bit count value at which the next transfer completes the table.
  localparam logic [N_IN:0] LAST_CNT = (N_IN + 1)'(TBL_W - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [N_IN:0]     r_bit_cnt;
  logic [TBL_W-1:0]  r_shadow;
  logic [TBL_W-1:0]  r_table;
  logic [N_IN-1:0]   r_in_q;
  logic              r_out;
  logic              r_out_valid;

  logic              w_cfg_ready;
  logic              w_xfer;
  logic              w_commit;
  logic              w_change;
  logic              w_load;
  logic              w_done;
  logic [N_IN-1:0]   w_tbl_idx;

  assign cfg_ready = w_cfg_ready;
  assign out       = r_out;
  assign out_valid = r_out_valid;

  assign w_xfer   = cfg_valid && w_cfg_ready;
  assign w_commit = (r_state == COMMIT);
  assign w_change = (in != r_in_q);
  // A commit invalidates the output just like an input change does.
  assign w_load   = w_change || w_commit;
  // Table MSB belongs to in == 0, so the bit index is (TBL_W-1 - in) == ~in.
  assign w_tbl_idx = ~r_in_q;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state and cfg handshake; abort only matters in LOAD and wins there.
  always_comb begin
    w_state_next = r_state;
    w_cfg_ready  = 1'b1;
    case (r_state)
      IDLE: begin
        if (cfg_valid) w_state_next = LOAD;
      end
      LOAD: begin
        if (cfg_abort) begin
          w_state_next = IDLE;
        end else if (cfg_valid && (r_bit_cnt == LAST_CNT)) begin
          w_state_next = COMMIT;
        end
      end
      COMMIT: begin
        w_cfg_ready  = 1'b0;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Shadow shift register, bit counter and atomic table swap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow  <= '0;
      r_bit_cnt <= '0;
      r_table   <= RESET_TABLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_shadow  <= {r_shadow[TBL_W-2:0], cfg_data};
            r_bit_cnt <= (N_IN + 1)'(1);
          end
        end
        LOAD: begin
          if (cfg_abort) begin
            r_bit_cnt <= '0;
          end else if (w_xfer) begin
            r_shadow  <= {r_shadow[TBL_W-2:0], cfg_data};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        COMMIT: begin
          r_table   <= r_shadow;
          r_bit_cnt <= '0;
        end
        default: r_bit_cnt <= '0;
      endcase
    end
  end

  // Input capture and registered lookup once the vector has settled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_q      <= '0;
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_in_q <= in;
      if (w_load) begin
        r_out_valid <= 1'b0;
      end else if (w_done && !r_out_valid) begin
        r_out       <= r_table[w_tbl_idx];
        r_out_valid <= 1'b1;
      end
    end
  end

  tt_settle_timer #(
    .DELAY (DELAY)
  ) u_settle (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_load),
    .done  (w_done)
  );

endmodule : truth_table_eval
